// File: rtl/ibex_irq_arbiter.sv
// Interrupt front-end: synchronises irq pins, latches edge-type fast irqs, masks and
// prioritises them, and presents one cause to the controller with a req/ack handshake.
// Optional stats outputs (ack count, worst req-to-ack latency): define IBEX_IRQ_ARB_STATS_EN.
module ibex_irq_arbiter #(
    parameter int unsigned SyncStages = 2,
    parameter logic [14:0] EdgeMask   = 15'h0000,
    parameter bit          ResetAll   = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [17:0] irqs_i,
    input  logic        irq_nm_i,
    input  logic [17:0] mie_i,
    input  logic        mstatus_mie_i,
    input  logic        debug_mode_i,
    input  logic        irq_ack_i,
    input  logic        nmi_clear_i,
    output logic        irq_req_o,
    output logic [5:0]  irq_cause_o,
    output logic [17:0] irq_pending_o,
    output logic        nmi_active_o
`ifdef IBEX_IRQ_ARB_STATS_EN
    ,
    output logic [15:0] irq_ack_cnt_o,
    output logic [7:0]  irq_max_lat_o
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

    localparam logic [5:0] CauseNmi      = 6'h3F;
    localparam logic [5:0] CauseExternal = 6'h2B;
    localparam logic [5:0] CauseSoftware = 6'h23;
    localparam logic [5:0] CauseTimer    = 6'h27;

    state_e      state_q, state_d;
    logic [5:0]  cause_q, cause_d;
    logic        nmi_active_q, nmi_active_d;

    logic [SyncStages-1:0][18:0] sync_q;
    logic [18:0] synced;
    logic [14:0] edge_prev_q;
    logic [14:0] edge_pend_q, edge_pend_d;
    logic [14:0] edge_set, edge_clr;
    logic [17:0] pending;
    logic [17:0] el;
    logic        nmi_el;
    logic        win_valid;
    logic [5:0]  win;
    logic        still;
    logic        ack_take;

    // Sync flops reset to zero in either ResetAll setting.
    logic unused_reset_all;
    assign unused_reset_all = ResetAll;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {irq_nm_i, irqs_i};
            for (int i = 1; i < SyncStages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced = sync_q[SyncStages-1];

    // A newly detected edge beats the ack clear of the same bit.
    assign edge_set    = synced[14:0] & ~edge_prev_q & EdgeMask;
    assign ack_take    = (state_q == REQ) && irq_ack_i;
    assign edge_clr    = (ack_take && cause_q[5:4] == 2'b11 && cause_q != CauseNmi)
                         ? (15'(1) << cause_q[3:0]) : 15'h0000;
    assign edge_pend_d = (edge_pend_q & ~edge_clr) | edge_set;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            edge_prev_q <= '0;
            edge_pend_q <= '0;
        end else begin
            edge_prev_q <= synced[14:0];
            edge_pend_q <= edge_pend_d;
        end
    end

    assign pending = {synced[17:15], (synced[14:0] & ~EdgeMask) | (edge_pend_q & EdgeMask)};
    assign el      = pending & mie_i & {18{mstatus_mie_i & ~debug_mode_i}};
    assign nmi_el  = synced[18] & ~nmi_active_q & ~debug_mode_i;

    assign win_valid = nmi_el | (|el);

    // Later assignments override earlier ones, so order is lowest priority first.
    always_comb begin
        win = 6'h00;
        if (el[16]) win = CauseTimer;
        if (el[17]) win = CauseSoftware;
        if (el[15]) win = CauseExternal;
        for (int k = 14; k >= 0; k--) begin
            if (el[k]) win = {2'b11, 4'(k)};
        end
        if (nmi_el) win = CauseNmi;
    end

    // Whether the presented source still qualifies; NMI only yields to debug entry.
    always_comb begin
        still = 1'b0;
        if (cause_q == CauseNmi)                still = ~debug_mode_i;
        else if (cause_q == CauseExternal)      still = el[15];
        else if (cause_q == CauseSoftware)      still = el[17];
        else if (cause_q == CauseTimer)         still = el[16];
        else if (cause_q[5:4] == 2'b11)         still = el[cause_q[3:0]];
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = REQ;
                    cause_d = win;
                end
            end
            REQ: begin
                if (irq_ack_i)   state_d = HOLD;
                else if (!still) state_d = IDLE;
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign nmi_active_d = (ack_take && cause_q == CauseNmi) | (nmi_active_q & ~nmi_clear_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cause_q      <= 6'h00;
            nmi_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            nmi_active_q <= nmi_active_d;
        end
    end

    assign irq_req_o     = (state_q == REQ);
    assign irq_cause_o   = cause_q;
    assign irq_pending_o = pending;
    assign nmi_active_o  = nmi_active_q;

`ifdef IBEX_IRQ_ARB_STATS_EN
    logic [15:0] ack_cnt_q;
    logic [7:0]  lat_q, max_lat_q;

    // lat_q counts REQ cycles including the ack cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_cnt_q <= '0;
            lat_q     <= '0;
            max_lat_q <= '0;
        end else begin
            if (ack_take && ack_cnt_q != 16'hFFFF) ack_cnt_q <= ack_cnt_q + 16'd1;
            if (state_q == IDLE && state_d == REQ)            lat_q <= 8'd1;
            else if (state_q == REQ && lat_q != 8'hFF)        lat_q <= lat_q + 8'd1;
            if (ack_take && lat_q > max_lat_q)                max_lat_q <= lat_q;
        end
    end

    assign irq_ack_cnt_o = ack_cnt_q;
    assign irq_max_lat_o = max_lat_q;
`endif

endmodule
